// File: rtl/edge_sync_if.sv
// Bus bundle for edge_sync_bank: raw inputs and qualifiers in, synchronised levels, pulses and edge count out.
interface edge_sync_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] signal_in;
  logic             en;
  logic             cnt_clr;
  logic [WIDTH-1:0] signal_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output signal_in, en, cnt_clr,
    input  signal_out, rise, fall, any_edge, edge_cnt
  );

  modport slave (
    input  signal_in, en, cnt_clr,
    output signal_out, rise, fall, any_edge, edge_cnt
  );
endinterface

// File: rtl/edge_sync_bank.sv
// Multi-channel input synchroniser with optional per-channel debounce, rise/fall pulses and a saturating edge counter.
// Optional feature macro: EDGE_SYNC_DEBOUNCE_EN (per-channel debounce counters).
module edge_sync_bank #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter bit          INIT_LEVEL   = 1'b0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk_in,
  input  logic        rst,
  edge_sync_if.slave  bus
);

  if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CNT < 1) begin : g_bad_param
    $error("edge_sync_bank: illegal parameter value");
  end

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_edge_q, any_edge_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Sync chain shifts every cycle, independent of en
  always_comb begin
    stage_d[0] = bus.signal_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  assign synced = stage_q[SYNC_STAGES-1];

`ifdef EDGE_SYNC_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CNT + 1);

  logic [DB_W-1:0] db_cnt_q [WIDTH];
  logic [DB_W-1:0] db_cnt_d [WIDTH];

  // New level accepted only after DEBOUNCE_CNT consecutive cycles of disagreement
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (bus.en) begin
        if (synced[i] == out_q[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CNT - 1)) begin
          out_d[i]    = synced[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end
`else
  always_comb begin
    out_d = out_q;
    if (bus.en) out_d = synced;
  end
`endif

  always_comb begin
    rise_d     = {WIDTH{bus.en}} & ~out_q &  out_d;
    fall_d     = {WIDTH{bus.en}} &  out_q & ~out_d;
    any_edge_d = |(rise_q | fall_q);
    edge_cnt_d = edge_cnt_q;
    // Clear wins over increment; count saturates at all-ones
    if (bus.cnt_clr) begin
      edge_cnt_d = '0;
    end else if (any_edge_d && (edge_cnt_q != {CNT_W{1'b1}})) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= {WIDTH{INIT_LEVEL}};
      out_q      <= {WIDTH{INIT_LEVEL}};
      rise_q     <= '0;
      fall_q     <= '0;
      any_edge_q <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= stage_d[s];
      out_q      <= out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_edge_q <= any_edge_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign bus.signal_out = out_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.any_edge   = any_edge_q;
  assign bus.edge_cnt   = edge_cnt_q;

endmodule

// File: doc/edge_sync_bank.md
Name: edge_sync_bank

Overview:
- Parametrised, multi-channel successor to the team's single-bit input synchroniser / edge detector.
- Brings WIDTH asynchronous inputs (buttons, switches, external strobes) into the clk_in domain through a configurable-depth flop chain.
- Optionally debounces each channel, then emits a registered level plus one-cycle rise/fall pulses per channel.
- Also provides a shared any-edge flag and a saturating edge-event counter for the ALU front panel / control logic.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE_CNT, 16, consecutive stable cycles required before a new level is accepted (>=1; only used when DEBOUNCE_EN is defined).
- INIT_LEVEL, 0, reset value of every sync stage and of signal_out (1-bit, applied to all channels).
- CNT_W, 8, width of edge_cnt.

Ports:
- clk_in  input  1  single system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- signal_in  input  WIDTH  raw asynchronous inputs.
- en  input  1  qualifier for level updates and pulses.
- cnt_clr  input  1  synchronous clear of edge_cnt.
- signal_out  output  WIDTH  synchronised (debounced) level.
- rise  output  WIDTH  one-cycle pulse on 0->1 of signal_out.
- fall  output  WIDTH  one-cycle pulse on 1->0 of signal_out.
- any_edge  output  1  registered OR of all rise|fall bits.
- edge_cnt  output  CNT_W  saturating count of cycles with any_edge=1.

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is asynchronous and active-high on rst.
- Reset values:
  - sync stages = INIT_LEVEL; signal_out = {WIDTH{INIT_LEVEL}}.
  - rise = fall = 0; any_edge = 0; edge_cnt = 0; debounce counters = 0.
- Reset asserted mid-operation: all of the above take effect immediately, without waiting for a clock edge.
- After reset release: if signal_in already differs from INIT_LEVEL, the edge is reported after normal latency. No spurious pulse when the inputs equal INIT_LEVEL.
- Sync chain:
  - Shifts every cycle regardless of en; stage[0] <= signal_in.
  - synced = stage[SYNC_STAGES-1].
  - Never use signal_in combinationally anywhere else.
- Level update without DEBOUNCE_EN: when en=1, signal_out <= synced.
- Per-channel debounce with DEBOUNCE_EN (counter width $clog2(DEBOUNCE_CNT+1)):
  - synced == signal_out -> counter <= 0.
  - synced != signal_out and counter == DEBOUNCE_CNT-1 -> signal_out <= synced, counter <= 0.
  - Otherwise counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CNT cycles resets the count and produces no output change.
- Pulses:
  - rise[i] <= en & ~signal_out[i] & next_out[i]; fall[i] <= en & signal_out[i] & ~next_out[i].
  - Both are registered, are high exactly one cycle, and coincide with the cycle signal_out shows its new value.
- en=0: signal_out and debounce counters hold, rise/fall are 0, and the sync chain keeps running. A level that changed while en=0 is accepted (with pulse) after en returns to 1, subject to debounce.
- Latency (input stable before edge 1, en=1):
  - Without DEBOUNCE_EN: signal_out and pulse visible after edge SYNC_STAGES+1.
  - With DEBOUNCE_EN: visible after edge SYNC_STAGES+DEBOUNCE_CNT. DEBOUNCE_CNT=1 equals the non-debounced latency.
- any_edge: registered one cycle after the rise/fall bits it summarises.
- edge_cnt:
  - Increments when any_edge=1 and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces 0 and wins over a simultaneous increment.
- Simultaneous edges on several channels: each channel pulses independently in the same cycle; edge_cnt increments by 1 (counts cycles, not channels).

Optional Feature:
- Macro: EDGE_SYNC_DEBOUNCE_EN.
- Defined: per-channel debounce counters are instantiated as described above.
- Undefined: no counters are instantiated, DEBOUNCE_CNT is ignored, and signal_out follows synced with a single register stage.

Test Plan:
- Reset: hold rst=1 with signal_in=4'hF, INIT_LEVEL=0 -> all outputs 0. After release and en=1, no debounce -> signal_out=4'hF and rise=4'hF for one cycle at edge 3; edge_cnt=1 after edge 4.
- Debounce on, DEBOUNCE_CNT=16:
  - Ch0 high pulse 10 cycles wide -> no change on signal_out[0], rise[0] stays 0.
  - Ch0 high 30 cycles -> rise[0] at edge 2+16=18 after the input edge. fall[0] 18 edges after the input falls.
- Enable gating: en=0 while ch1 toggles 0->1 -> signal_out[1]=0, rise=0. Raise en -> rise[1] one cycle later (no debounce).
- Simultaneous events: ch0 rises and ch2 falls in the same cycle -> rise=4'b0001 and fall=4'b0100 in the same cycle, any_edge one cycle, edge_cnt +1.
- Counter, CNT_W=8: 300 edge events -> edge_cnt=255 held. Assert cnt_clr on an edge cycle -> edge_cnt=0.
- Async reset mid-debounce: assert rst between clock edges while a counter is at 9 -> outputs clear immediately. After release, a stable input needs a full 16-cycle count.
